// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, ALU opcode encoding, issue-stage FSM state
//                type and command record for the ALU issue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 3;

  // ALU opcode encoding
  localparam logic [ALU_SEL_W-1:0] OP_ADD  = 3'd0;
  localparam logic [ALU_SEL_W-1:0] OP_SUB  = 3'd1;
  localparam logic [ALU_SEL_W-1:0] OP_MUL  = 3'd2;
  localparam logic [ALU_SEL_W-1:0] OP_AND  = 3'd3;
  localparam logic [ALU_SEL_W-1:0] OP_OR   = 3'd4;
  localparam logic [ALU_SEL_W-1:0] OP_NOT  = 3'd5;
  localparam logic [ALU_SEL_W-1:0] OP_XOR  = 3'd6;
  localparam logic [ALU_SEL_W-1:0] OP_XNOR = 3'd7;

  // Issue-stage control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One queued ALU command at the default widths
  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_SEL_W-1:0]  sel;
  } cmd_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous FIFO for ALU commands. Occupancy counter tells
//                full from empty; pointers wrap naturally since DEPTH is a
//                power of two (minimum 2). Push is ignored while full, pop is
//                ignored while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push, w_do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign data_o    = mem_q[rptr_q];

  // Storage array: written at the write pointer on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count as is
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + 1'b1;
      if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
      if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
      else if (!w_do_push && w_do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Clocked valid/ready wrapper around a combinational ALU.
//                Commands are queued in alu_cmd_fifo, issued one at a time on
//                registered operands, and the ALU result is captured one
//                cycle later with a masked carry and a zero flag.
//                Optional macro ALU_ISSUE_STATS_EN adds stat_ops and
//                stat_carries 16-bit wrapping counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_zero,
  output logic [SEL_W-1:0]  out_sel
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_carries
`endif
);

  localparam int CMD_W = 2*DATA_W + SEL_W;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] w_head;
  logic             w_full, w_empty, w_pop;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  ({in_a, in_b, in_sel}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign in_ready = !w_full;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   w_capture, w_release;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one command in flight, result held until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!w_empty) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = w_empty ? IDLE : EXEC;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs: pop loads the ALU operands, capture latches the result
  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (state_q)
      IDLE: w_pop = !w_empty;
      EXEC: w_capture = 1'b1;
      RESP: begin
        w_release = out_ready;
        w_pop     = out_ready && !w_empty;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU operand registers (hold last value when not loading)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;

  // Load the FIFO head into the operand registers on each pop
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else if (w_pop) begin
      {alu_a_q, alu_b_q, alu_sel_q} <= w_head;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;

  // ---------------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------------
  logic              w_carry_masked;
  logic [DATA_W-1:0] out_result_q;
  logic              out_carry_q, out_zero_q, out_valid_q;
  logic [SEL_W-1:0]  out_sel_q;

  // Carry is only meaningful for add; every other opcode reports 0
  assign w_carry_masked = (alu_sel_q == SEL_W'(OP_ADD)) ? alu_carry : 1'b0;

  // Capture ALU outputs at the end of EXEC; drop valid once accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_sel_q    <= '0;
    end else if (w_capture) begin
      out_valid_q  <= 1'b1;
      out_result_q <= alu_result;
      out_carry_q  <= w_carry_masked;
      out_zero_q   <= (alu_result == '0);
      out_sel_q    <= alu_sel_q;
    end else if (w_release) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign out_sel    = out_sel_q;

`ifdef ALU_ISSUE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (wrap naturally at 16 bits)
  // ---------------------------------------------------------------------------
  logic [15:0] stat_ops_q, stat_carries_q;

  // Count every executed op and every op that captured a carry
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q     <= '0;
      stat_carries_q <= '0;
    end else if (w_capture) begin
      stat_ops_q <= stat_ops_q + 16'd1;
      if (w_carry_masked) stat_carries_q <= stat_carries_q + 16'd1;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_carries = stat_carries_q;
`endif

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage with a behavioural
//                ALU on the alu_* side and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_sel;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carry;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic       out_carry, out_zero;
  logic [2:0] out_sel;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_carries;
`endif

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_sel    (out_sel)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_carries (stat_carries)
`endif
  );

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic [2:0] s;
  } exp_t;

  typedef struct {
    cmd_t cmd;
    exp_t e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_ops  = 0;
  int   n_carry = 0;
  exp_t sb[$];
  exp_t got[$];
  int   hs_cyc[$];
  vec_t vecs[12];

  // Behavioural ALU; carry is the adder carry-out whatever the opcode
  function automatic logic [8:0] alu_model(logic [7:0] a, logic [7:0] b, logic [2:0] s);
    logic [8:0]  sum;
    logic [15:0] prod;
    logic [7:0]  r;
    sum  = {1'b0, a} + {1'b0, b};
    prod = a * b;
    case (s)
      3'd0: r = sum[7:0];
      3'd1: r = a - b;
      3'd2: r = prod[7:0];
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ~a;
      3'd6: r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return {sum[8], r};
  endfunction

  function automatic exp_t exp_of(logic [7:0] a, logic [7:0] b, logic [2:0] s);
    exp_t       e;
    logic [8:0] m;
    m   = alu_model(a, b, s);
    e.r = m[7:0];
    e.c = (s == 3'd0) ? m[8] : 1'b0;
    e.z = (m[7:0] == 8'h00);
    e.s = s;
    return e;
  endfunction

  always_comb begin
    {alu_carry, alu_result} = alu_model(alu_a, alu_b, alu_sel);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every accepted result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back('{r: out_result, c: out_carry, z: out_zero, s: out_sel});
      hs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_pair(input exp_t g, input exp_t e);
    check("out_result", 32'(g.r), 32'(e.r));
    check("out_carry",  32'(g.c), 32'(e.c));
    check("out_zero",   32'(g.z), 32'(e.z));
    check("out_sel",    32'(g.s), 32'(e.s));
  endtask

  task automatic push_cmd(input cmd_t c, input exp_t e);
    int g = 0;
    in_a = c.a; in_b = c.b; in_sel = c.sel; in_valid = 1'b1;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready stayed 0, required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Wait for all expected results, then compare in order
  task automatic drain_check(input string name);
    int g = 0;
    while (got.size() < sb.size() && g < 400) begin
      @(posedge clk); g++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_count"}, 32'(got.size()), 32'(sb.size()));
    for (int i = 0; i < got.size() && i < sb.size(); i++) cmp_pair(got[i], sb[i]);
    foreach (got[i]) begin
      n_ops++;
      if (got[i].c) n_carry++;
    end
    got.delete();
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int   k;
    logic r;
    cmd_t fc[6];

    // Directed vectors with hand-computed expectations
    vecs[0]  = '{'{8'hF0, 8'h20, 3'd0}, '{8'h10, 1'b1, 1'b0, 3'd0}};
    vecs[1]  = '{'{8'h05, 8'h05, 3'd1}, '{8'h00, 1'b0, 1'b1, 3'd1}};
    vecs[2]  = '{'{8'hFF, 8'h01, 3'd1}, '{8'hFE, 1'b0, 1'b0, 3'd1}};
    vecs[3]  = '{'{8'hFF, 8'h01, 3'd0}, '{8'h00, 1'b1, 1'b1, 3'd0}};
    vecs[4]  = '{'{8'h0C, 8'h0A, 3'd0}, '{8'h16, 1'b0, 1'b0, 3'd0}};
    vecs[5]  = '{'{8'h0C, 8'h0A, 3'd1}, '{8'h02, 1'b0, 1'b0, 3'd1}};
    vecs[6]  = '{'{8'h0C, 8'h0A, 3'd2}, '{8'h78, 1'b0, 1'b0, 3'd2}};
    vecs[7]  = '{'{8'h0C, 8'h0A, 3'd3}, '{8'h08, 1'b0, 1'b0, 3'd3}};
    vecs[8]  = '{'{8'h0C, 8'h0A, 3'd4}, '{8'h0E, 1'b0, 1'b0, 3'd4}};
    vecs[9]  = '{'{8'h0C, 8'h0A, 3'd5}, '{8'hF3, 1'b0, 1'b0, 3'd5}};
    vecs[10] = '{'{8'h0C, 8'h0A, 3'd6}, '{8'h06, 1'b0, 1'b0, 3'd6}};
    vecs[11] = '{'{8'h0C, 8'h0A, 3'd7}, '{8'hF9, 1'b0, 1'b0, 3'd7}};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_a",     32'(alu_a), 32'd0);
    check("rst_alu_b",     32'(alu_b), 32'd0);
    check("rst_alu_sel",   32'(alu_sel), 32'd0);
    check("rst_out_result",32'(out_result), 32'd0);
    check("rst_out_cz",    32'({out_carry, out_zero}), 32'd0);
    check("rst_out_sel",   32'(out_sel), 32'd0);
    @(posedge clk); #1;

    // Latency: push at edge n, valid after edge n+2
    push_cmd(vecs[0].cmd, vecs[0].e);
    @(negedge clk); check("lat_n",  32'(out_valid), 32'd0);
    @(negedge clk); check("lat_n1", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_n2", 32'(out_valid), 32'd1);
    drain_check("single_add");

    // Carry mask / zero flag vectors
    for (int i = 1; i < 4; i++) push_cmd(vecs[i].cmd, vecs[i].e);
    drain_check("mask_zero");

    // Back-to-back stream of all opcodes
    hs_cyc.delete();
    for (int i = 4; i < 12; i++) push_cmd(vecs[i].cmd, vecs[i].e);
    drain_check("stream");
    check("stream_hs_count", 32'(hs_cyc.size()), 32'd8);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("stream_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

    // Full / back-pressure: 1 in flight + 4 queued, 6th refused
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) fc[i] = '{8'(8'h31 + 8'(i*17)), 8'(8'hD2 - 8'(i*5)), 3'(i)};
    k = 0;
    for (int t = 0; t < 10; t++) begin
      if (k < 6) begin
        in_valid = 1'b1; in_a = fc[k].a; in_b = fc[k].b; in_sel = fc[k].sel;
      end else begin
        in_valid = 1'b0;
      end
      r = in_ready;
      @(posedge clk);
      if (in_valid && r) begin
        sb.push_back(exp_of(fc[k].a, fc[k].b, fc[k].sel));
        k++;
      end
      #1;
    end
    in_valid = 1'b0;
    check("full_accepted", 32'(k), 32'd5);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_held_valid", 32'(out_valid), 32'd1);
    hs_cyc.delete();
    out_ready = 1'b1;
    drain_check("full");
    check("full_hs_count", 32'(hs_cyc.size()), 32'd5);

    // Mid-operation reset: c1 in RESP, c2 in EXEC with 2 still queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(vecs[4+i].cmd, vecs[4+i].e);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    rst = 1'b1;
    check("rst_mid_first_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) cmp_pair(got[0], sb[0]);
    got.delete(); sb.delete();
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready), 32'd1);
    check("mid_rst_alu",       32'({alu_a, alu_b, 5'(alu_sel)}), 32'd0);
    n_ops = 0; n_carry = 0;
    rst = 1'b0; out_ready = 1'b1;
    hs_cyc.delete();
    repeat (12) @(posedge clk);
    #1 check("no_stale_results", 32'(hs_cyc.size()), 32'd0);

    // Recovery after reset: two carrying adds
    push_cmd(vecs[0].cmd, vecs[0].e);
    push_cmd(vecs[3].cmd, vecs[3].e);
    drain_check("post_reset");

`ifdef ALU_ISSUE_STATS_EN
    check("stat_ops",     32'(stat_ops), 32'(n_ops));
    check("stat_carries", 32'(stat_carries), 32'(n_carry));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_issue_stage
`default_nettype wire
